// File: rtl/stim_channel_encoder.sv
// Stimulation channel encoder: captures per-channel request edges into a sticky
// pending set, arbitrates, and offers one 3-bit channel index at a time over Valid/Ack.
module stim_channel_encoder #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Req,
    input  logic       Enable,
    input  logic       Ack,
    output logic [2:0] Bout,
    output logic       Valid,
    output logic [7:0] Pend,
    output logic       Miss
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_req_q;
    logic [7:0] r_pend;
    logic [2:0] r_bout;
    logic [2:0] r_ptr;
    logic       r_miss;

    logic [7:0] w_rise;
    logic [7:0] w_clr;
    logic [7:0] w_pend_eff;
    logic [2:0] w_start;
    logic [2:0] w_sel;
    logic       w_load;
    logic       w_ack_take;

    // Returns the first set bit of pend at or after start, wrapping 7->0.
    // Scanning offsets high-to-low lets the closest hit win without a break.
    function automatic logic [2:0] f_select(input logic [7:0] pend, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] sel;
        sel = start;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (pend[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    assign w_rise     = Req & ~r_req_q;
    assign w_start    = RR_EN ? r_ptr : 3'd0;
    assign w_sel      = f_select(r_pend, w_start);
    assign w_clr      = w_ack_take ? (8'b0000_0001 << r_bout) : 8'b0000_0000;
    // A rise on the channel being acknowledged re-arms it instead of counting as a miss.
    assign w_pend_eff = r_pend & ~w_clr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Enable && (r_pend != 8'h00)) begin
                    w_state_nxt = S_OFFER;
                    w_load      = 1'b1;
                end
            end
            S_OFFER: begin
                if (Ack) begin
                    w_state_nxt = S_IDLE;
                    w_ack_take  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_req_q <= 8'hFF;
            r_pend  <= 8'h00;
            r_bout  <= 3'd0;
            r_ptr   <= 3'd0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= Req;
            r_pend  <= w_pend_eff | w_rise;
            r_miss  <= |(w_rise & w_pend_eff);
            if (w_load) begin
                r_bout <= w_sel;
            end
            if (w_ack_take) begin
                r_ptr <= r_bout + 3'd1;
            end
        end
    end

    assign Bout  = r_bout;
    assign Valid = (r_state == S_OFFER);
    assign Pend  = r_pend;
    assign Miss  = r_miss;

    // An outstanding offer must not change until it is acknowledged.
    a_offer_stable : assert property (@(posedge CLK) disable iff (RST)
        (Valid && !Ack) |=> (Valid && $stable(Bout)));

    a_gap_after_ack : assert property (@(posedge CLK) disable iff (RST)
        (Valid && Ack) |=> !Valid);

endmodule

// File: tb/tb_stim_channel_encoder.sv
// Bench for stim_channel_encoder: a round-robin and a fixed-priority instance,
// expected grant indices queued as requests are driven and popped as offers appear.
module tb_stim_channel_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req   [2];
    logic       en    [2];
    logic       ack   [2];
    logic [2:0] bout  [2];
    logic       valid [2];
    logic [7:0] pend  [2];
    logic       miss  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];

    always #5 clk = ~clk;

    stim_channel_encoder #(.RR_EN(1'b1)) u_rr (
        .CLK(clk), .RST(rst), .Req(req[0]), .Enable(en[0]), .Ack(ack[0]),
        .Bout(bout[0]), .Valid(valid[0]), .Pend(pend[0]), .Miss(miss[0])
    );

    stim_channel_encoder #(.RR_EN(1'b0)) u_fp (
        .CLK(clk), .RST(rst), .Req(req[1]), .Enable(en[1]), .Ack(ack[1]),
        .Bout(bout[1]), .Valid(valid[1]), .Pend(pend[1]), .Miss(miss[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int idx);
        if (d == 0) q0.push_back(idx);
        else        q1.push_back(idx);
    endtask

    function automatic int pop(input int d);
        int v;
        v = 99;
        if (d == 0) begin
            if (q0.size() > 0) v = q0.pop_front();
        end else begin
            if (q1.size() > 0) v = q1.pop_front();
        end
        return v;
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        req[0] = 8'h00;
        req[1] = 8'h00;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Wait (bounded) for an offer, compare against the scoreboard, acknowledge it.
    task automatic serve(input int d, input logic [7:0] exp_pend, output int waited);
        int exp_idx;
        waited = 0;
        while (!valid[d] && waited < 20) begin
            tick();
            waited++;
        end
        check("offer_seen", int'(valid[d]), 1);
        exp_idx = pop(d);
        check("bout", int'(bout[d]), exp_idx);
        ack[d] = 1'b1;
        tick();
        ack[d] = 1'b0;
        check("valid_drop", int'(valid[d]), 0);
        check("pend_after_ack", int'(pend[d]), int'(exp_pend));
        check("miss_on_ack", int'(miss[d]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int exp_idx;

        // Lines already high through reset release must not be captured.
        rst    = 1'b1;
        req[0] = 8'h05;
        req[1] = 8'h00;
        en[0]  = 1'b1;
        en[1]  = 1'b1;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        tick();
        tick();
        check("rst_pend", int'(pend[0]), 0);
        check("rst_valid", int'(valid[0]), 0);
        check("rst_bout", int'(bout[0]), 0);
        check("rst_miss", int'(miss[0]), 0);
        check("rst_valid_fp", int'(valid[1]), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_pend", int'(pend[0]), 0);
            check("held_valid", int'(valid[0]), 0);
        end
        req[0] = 8'h01;
        tick();
        req[0] = 8'h05;
        push(0, 2);
        tick();
        check("rise_pend", int'(pend[0]), 8'h04);
        check("rise_valid_early", int'(valid[0]), 0);
        tick();
        check("rise_latency_valid", int'(valid[0]), 1);
        serve(0, 8'h00, w);

        // Round-robin from Ptr=0 over channels 1,3,6 with one idle cycle between offers.
        do_reset();
        req[0] = 8'h4A;
        tick();
        check("rr_pend", int'(pend[0]), 8'h4A);
        push(0, 1);
        push(0, 3);
        push(0, 6);
        serve(0, 8'h48, w);
        serve(0, 8'h40, w);
        check("rr_gap1", w, 1);
        serve(0, 8'h00, w);
        check("rr_gap2", w, 1);

        // Wrap after last grant 6, and fixed priority on the same pending set.
        req[0] = 8'h00;
        tick();
        req[0] = 8'h81;
        tick();
        check("wrap_pend", int'(pend[0]), 8'h81);
        push(0, 7);
        push(0, 0);
        serve(0, 8'h01, w);
        serve(0, 8'h00, w);
        req[1] = 8'h81;
        tick();
        push(1, 0);
        push(1, 7);
        serve(1, 8'h80, w);
        serve(1, 8'h00, w);

        // Offer held across Ack=0 and Enable toggling; Enable low blocks the next one.
        req[0] = 8'h00;
        tick();
        req[0] = 8'h30;
        push(0, 4);
        push(0, 5);
        tick();
        tick();
        check("hold_valid0", int'(valid[0]), 1);
        exp_idx = pop(0);
        check("hold_bout0", int'(bout[0]), exp_idx);
        for (int i = 0; i < 5; i++) begin
            en[0] = (i % 2) != 0;
            tick();
            check("hold_valid", int'(valid[0]), 1);
            check("hold_bout", int'(bout[0]), exp_idx);
        end
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check("hold_ack_valid", int'(valid[0]), 0);
        check("hold_ack_pend", int'(pend[0]), 8'h20);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("disabled_valid", int'(valid[0]), 0);
            check("disabled_pend", int'(pend[0]), 8'h20);
        end
        en[0] = 1'b1;
        serve(0, 8'h00, w);

        // Repeated rise on a pending channel, then a rise coinciding with its Ack.
        req[0] = 8'h00;
        en[0]  = 1'b0;
        tick();
        req[0] = 8'h04;
        tick();
        check("miss_first_pend", int'(pend[0]), 8'h04);
        check("miss_first", int'(miss[0]), 0);
        req[0] = 8'h00;
        tick();
        req[0] = 8'h04;
        tick();
        check("miss_pulse", int'(miss[0]), 1);
        check("miss_pend", int'(pend[0]), 8'h04);
        tick();
        check("miss_one_cycle", int'(miss[0]), 0);
        push(0, 2);
        push(0, 2);
        en[0] = 1'b1;
        tick();
        check("coin_valid", int'(valid[0]), 1);
        check("coin_bout", int'(bout[0]), pop(0));
        req[0] = 8'h00;
        tick();
        req[0] = 8'h04;
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        check("coin_valid_drop", int'(valid[0]), 0);
        check("coin_pend", int'(pend[0]), 8'h04);
        check("coin_miss", int'(miss[0]), 0);
        serve(0, 8'h00, w);
        check("coin_reoffer_gap", w, 1);

        // Reset in the middle of an offer drops it and restarts arbitration at Ptr=0.
        req[0] = 8'h00;
        tick();
        req[0] = 8'h41;
        tick();
        check("mid_pend", int'(pend[0]), 8'h41);
        tick();
        check("mid_valid", int'(valid[0]), 1);
        check("mid_bout", int'(bout[0]), 6);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", int'(valid[0]), 0);
        check("mid_rst_pend", int'(pend[0]), 0);
        check("mid_rst_bout", int'(bout[0]), 0);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_pend", int'(pend[0]), 0);
        check("post_rst_valid", int'(valid[0]), 0);
        req[0] = 8'h00;
        tick();
        req[0] = 8'h41;
        push(0, 0);
        push(0, 6);
        tick();
        serve(0, 8'h40, w);
        serve(0, 8'h00, w);

        check("scoreboard_empty_rr", q0.size(), 0);
        check("scoreboard_empty_fp", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
